// File: rtl/isqrt_seq_if.sv
// Producer/consumer bus for isqrt_seq: start/din request, busy/valid/root(/rem) result.
// The rem signal exists only when ISQRT_REM_EN is defined.
interface isqrt_seq_if #(
    parameter int WIDTH = 16
);
    localparam int RW = WIDTH / 2;

    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             valid;
    logic [RW-1:0]    root;
`ifdef ISQRT_REM_EN
    logic [RW:0]      rem;
`endif

    modport master (
        output start,
        output din,
        input  busy,
        input  valid,
        input  root
`ifdef ISQRT_REM_EN
        , input rem
`endif
    );

    modport slave (
        input  start,
        input  din,
        output busy,
        output valid,
        output root
`ifdef ISQRT_REM_EN
        , output rem
`endif
    );
endinterface

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one root bit per clock, controller and datapath together.
// Optional macro ISQRT_REM_EN adds the registered remainder output.
module isqrt_seq #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    isqrt_seq_if.slave  bus,
    output logic [1:0]  state
);
    localparam int RW = WIDTH / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [RW:0]      wrem_q;
    logic [RW-1:0]    wroot_q;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    root_q;
    logic             busy_q;
    logic             valid_q;
`ifdef ISQRT_REM_EN
    logic [RW:0]      rem_q;
`endif

    logic [RW+2:0]    trial;
    logic [RW+2:0]    divisor;
    logic             fits;
    logic [RW:0]      wrem_d;
    logic [RW-1:0]    wroot_d;

    // One extra top bit on trial/divisor keeps the compare exact; the difference always fits RW+1 bits.
    always_comb begin
        trial   = {wrem_q, x_q[WIDTH-1 -: 2]};
        divisor = {1'b0, wroot_q, 2'b01};
        fits    = (trial >= divisor);
        wrem_d  = fits ? (trial[RW:0] - divisor[RW:0]) : trial[RW:0];
        wroot_d = {wroot_q[RW-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            wrem_q  <= '0;
            wroot_q <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef ISQRT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        x_q     <= bus.din;
                        wrem_q  <= '0;
                        wroot_q <= '0;
                        cnt_q   <= CW'(RW - 1);
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    x_q     <= x_q << 2;
                    wrem_q  <= wrem_d;
                    wroot_q <= wroot_d;
                    if (cnt_q == '0) begin
                        root_q  <= wroot_d;
`ifdef ISQRT_REM_EN
                        rem_q   <= wrem_d;
`endif
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.root  = root_q;
`ifdef ISQRT_REM_EN
    assign bus.rem   = rem_q;
`endif
    assign state     = state_q;
endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: WIDTH=16 vectors, random ops, corner sequences, exhaustive WIDTH=8.
// Works with and without ISQRT_REM_EN.
module tb_isqrt_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] stateA;
    logic [1:0] stateB;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    isqrt_seq_if #(.WIDTH(16)) busA ();
    isqrt_seq_if #(.WIDTH(8))  busB ();

    isqrt_seq #(.WIDTH(16)) dutA (.clk(clk), .reset(reset), .bus(busA.slave), .state(stateA));
    isqrt_seq #(.WIDTH(8))  dutB (.clk(clk), .reset(reset), .bus(busB.slave), .state(stateB));

    typedef struct {
        logic [15:0] din;
        longint      expRoot;
        longint      expRem;
    } vec_t;

    vec_t vecs[10];

    // Reference: smallest-first search for floor(sqrt(v)).
    function automatic longint refRoot(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint remA();
`ifdef ISQRT_REM_EN
        return longint'(busA.rem);
`else
        return 0;
`endif
    endfunction

    function automatic longint remB();
`ifdef ISQRT_REM_EN
        return longint'(busB.rem);
`else
        return 0;
`endif
    endfunction

    // Launch one op on the 16-bit unit; optionally pulse start with din=9 at CALC cycle 3.
    task automatic applyStimulus(input logic [15:0] d, input bit pulseMid,
                                 output int lat, output int busyCnt);
        @(negedge clk);
        busA.start = 1'b1;
        busA.din   = d;
        @(posedge clk);
        lat = 0;
        busyCnt = 0;
        @(negedge clk);
        busA.start = 1'b0;
        busA.din   = 16'($urandom);
        if (busA.busy) busyCnt++;
        while (!busA.valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (pulseMid && lat == 3) begin
                busA.start = 1'b1;
                busA.din   = 16'd9;
            end else begin
                busA.start = 1'b0;
            end
            if (busA.busy) busyCnt++;
        end
        busA.start = 1'b0;
    endtask

    task automatic checkResultA(input string name, input longint d);
        longint r;
        r = refRoot(d);
        checkOutput({name, "_valid"}, longint'(busA.valid), 1);
        checkOutput({name, "_root"}, longint'(busA.root), r);
`ifdef ISQRT_REM_EN
        checkOutput({name, "_rem"}, remA(), d - r * r);
`endif
    endtask

    initial begin
        int lat;
        int busyCnt;
        int cyc;
        int firstAt;
        int secondAt;
        bit sawValid;
        longint d;
        longint r;
        longint rm;
        longint root1;
        longint rem1;

        vecs[0] = '{16'd0,     0,   0};
        vecs[1] = '{16'd144,   12,  0};
        vecs[2] = '{16'd255,   15,  30};
        vecs[3] = '{16'd65535, 255, 510};
        vecs[4] = '{16'd1,     1,   0};
        vecs[5] = '{16'd2,     1,   1};
        vecs[6] = '{16'd3,     1,   2};
        vecs[7] = '{16'd100,   10,  0};
        vecs[8] = '{16'd65025, 255, 0};
        vecs[9] = '{16'd65024, 254, 508};

        busA.start = 1'b0;
        busA.din   = '0;
        busB.start = 1'b0;
        busB.din   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetState", longint'(stateA), 0);
        checkOutput("resetBusy", longint'(busA.busy), 0);
        checkOutput("resetValid", longint'(busA.valid), 0);
        checkOutput("resetRoot", longint'(busA.root), 0);
        checkOutput("resetRem", remA(), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].din, 1'b0, lat, busyCnt);
            checkOutput($sformatf("vec%0d_latency", i), lat, 8);
            checkOutput($sformatf("vec%0d_root", i), longint'(busA.root), vecs[i].expRoot);
`ifdef ISQRT_REM_EN
            checkOutput($sformatf("vec%0d_rem", i), remA(), vecs[i].expRem);
`endif
            checkOutput($sformatf("vec%0d_state", i), longint'(stateA), 2);
        end

        for (int i = 0; i < 25; i++) begin
            d = longint'($urandom_range(0, 65535));
            applyStimulus(16'(d), 1'b0, lat, busyCnt);
            checkOutput($sformatf("rand%0d_latency", i), lat, 8);
            checkResultA($sformatf("rand%0d", i), d);
        end

        // Start during CALC must be ignored; busy spans exactly the 8 iterations.
        applyStimulus(16'd100, 1'b1, lat, busyCnt);
        checkOutput("midStart_busyCycles", busyCnt, 8);
        checkOutput("midStart_latency", lat, 8);
        checkResultA("midStart", 100);
        @(negedge clk);
        checkOutput("midStart_holdDone", longint'(stateA), 2);

        // Reset at CALC cycle 4 aborts the op and clears the outputs.
        @(negedge clk);
        busA.start = 1'b1;
        busA.din   = 16'd40000;
        @(posedge clk);
        @(negedge clk);
        busA.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midReset_state", longint'(stateA), 0);
        checkOutput("midReset_busy", longint'(busA.busy), 0);
        checkOutput("midReset_valid", longint'(busA.valid), 0);
        checkOutput("midReset_root", longint'(busA.root), 0);
        reset = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busA.valid) sawValid = 1'b1;
        end
        checkOutput("midReset_noValid", longint'(sawValid), 0);

        // Start held high: back-to-back relaunch from DONE, din changes between ops.
        @(negedge clk);
        busA.start = 1'b1;
        busA.din   = 16'd50;
        @(posedge clk);
        @(negedge clk);
        busA.din = 16'd49;
        cyc = 0;
        firstAt = -1;
        secondAt = -1;
        root1 = 0;
        rem1 = 0;
        while (secondAt < 0 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (busA.valid) begin
                if (firstAt < 0) begin
                    firstAt = cyc;
                    root1 = longint'(busA.root);
                    rem1 = remA();
                end else if (cyc != firstAt + 1) begin
                    secondAt = cyc;
                end else begin
                    secondAt = -2;
                    cyc = 40;
                end
            end
        end
        busA.start = 1'b0;
        checkOutput("held_firstAt", firstAt, 8);
        checkOutput("held_gap", secondAt - firstAt, 9);
        checkOutput("held_root1", root1, 7);
        checkOutput("held_root2", longint'(busA.root), 7);
`ifdef ISQRT_REM_EN
        checkOutput("held_rem1", rem1, 1);
        checkOutput("held_rem2", remA(), 0);
`endif

        // Exhaustive 8-bit sweep on the small instance.
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            busB.start = 1'b1;
            busB.din   = 8'(v);
            @(posedge clk);
            @(negedge clk);
            busB.start = 1'b0;
            cyc = 0;
            while (!busB.valid && cyc < 20) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
            r = longint'(busB.root);
            rm = remB();
            checkOutput($sformatf("w8_%0d_latency", v), cyc, 4);
            checkOutput($sformatf("w8_%0d_root", v), r, refRoot(v));
`ifdef ISQRT_REM_EN
            checkOutput($sformatf("w8_%0d_identity", v), r * r + rm, v);
            checkOutput($sformatf("w8_%0d_remBound", v), longint'(rm <= 2 * r), 1);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
